register_file: RTL and testbench
================================

# register_file

Eight-entry, 16-bit general-purpose register file for the five-phase processor. It consumes the write-back address and write-enable produced by the instruction decode stage, and captures the result in a pending write-back latch. The pending write is committed during the write-back phase. During the decode phase it provides two registered operand read ports, with same-cycle bypass from the committing write.

## Interface
- DATA_W, 16, register and data width
- ADDR_W, 3, register index width (2**ADDR_W registers)
- clk  input  1  system clock; all state updates on rising edge
- reset  input  1  synchronous, active-high; clears all state
- phase  input  3  processor phase: 0 IF, 1 ID, 2 EX, 3 MEM, 4 WB; values 5–7 are idle
- read_add_a  input  ADDR_W  operand A index (Ra field)
- read_add_b  input  ADDR_W  operand B index (Rb field)
- write_add  input  ADDR_W  write-back index from decode
- writeOrder  input  1  write-back enable from decode
- write_data  input  DATA_W  result to be written back
- read_data_a  output  DATA_W  registered operand A
- read_data_b  output  DATA_W  registered operand B
- wb_pending  output  1  high while a captured write awaits commit

## Operation
- State:
  - reg array `r[0..7]`; no hardwired zero register, r0 is ordinary
  - pending latch: `p_add` (ADDR_W), `p_data` (DATA_W), `p_valid`
- Capture: when `phase==3`, load `p_add<=write_add`, `p_data<=write_data`, `p_valid<=writeOrder`.
  - A capture with `writeOrder==0` clears `p_valid`.
- Commit: when `phase==4` and `p_valid`, perform `r[p_add]<=p_data`, then clear `p_valid`.
  - When `phase==4` and `!p_valid`, the array is unchanged.
- Read: when `phase==1`, `read_data_a<=r[read_add_a]` and `read_data_b<=r[read_add_b]`.
  - In all other phases the read outputs hold their value.
- Bypass: if a read and a commit occur in the same cycle to the same index, the read returns `p_data`. This cannot arise under legal phase sequencing, but it is required for `phase` glitches and test injection.
- Phases 0, 2, 5, 6, 7: no state change.
- `wb_pending = p_valid`, driven combinationally from the flop.
- Width rules:
  - indices are used unsigned and unextended
  - data is stored verbatim with no sign handling
  - X on `write_add` while `writeOrder==0` must not corrupt any register

## Timing
- Reset values: all `r[i]=0`, `read_data_a=read_data_b=0`, `p_valid=0`, so `wb_pending=0`; `p_add` and `p_data` are 0.
- Reset has priority over capture, commit and read in the same cycle.
  - Reset mid-sequence (e.g. between capture and commit) discards the pending write; the target register stays 0.
- Latency:
  - read: outputs valid one edge after the `phase==1` cycle
  - write: the array is updated on the edge ending the `phase==4` cycle, so a read in the next instruction's ID phase sees it
- A capture with no following WB phase persists. A later `phase==3` overwrites it (last capture wins), and the earlier write is lost.
- Two consecutive `phase==4` cycles commit at most once.
- Simultaneous `phase==4` commit and a read of the same index: the bypass value is returned.
- The array and pending latch are edge-triggered flops; there are no combinational read paths to the outputs.

## Structure
- Shared package `proc_pkg`:
  - `DATA_W` and `ADDR_W`
  - phase encoding constants `PH_IF=0`, `PH_ID=1`, `PH_EX=2`, `PH_MEM=3`, `PH_WB=4`
- One sub-module is natural: `wb_latch`, which holds the pending write-back and owns its capture/commit/clear logic and the `wb_pending` output. The top level keeps the array, the read ports and the bypass mux.

## Test plan
- Reset then read:
  - after reset, `phase=1` with `read_add_a=3`, `read_add_b=7` gives both outputs 0x0000 and `wb_pending=0`
- Write then read:
  - `phase=3`, `write_add=5`, `writeOrder=1`, `write_data=0xBEEF` gives `wb_pending=1`
  - `phase=4` clears `wb_pending`
  - `phase=1` with `read_add_a=5` gives 0xBEEF
- Suppressed write:
  - `phase=3`, `write_add=2`, `writeOrder=0`, `write_data=0x1234`, then `phase=4`
  - `r2` stays at its prior value (0x0000 after reset) and `wb_pending` stays 0
- Reset mid-operation:
  - capture `write_add=1`, `write_data=0x00FF` at `phase=3`
  - assert `reset` during the `phase=4` cycle
  - a later read of `r1` gives 0x0000
- Last capture wins and bypass:
  - capture index 4 / 0x1111, then index 6 / 0x2222 with no WB phase between them
  - commit at `phase=4`: `r6=0x2222` and `r4` is unchanged
  - force `phase=4` with the read enable injected, `read_add_b=6`, `p_data=0x3333`: `read_data_b=0x3333`
- Sweep:
  - write `i*0x1001` to every `r[i]` for i=0..7, then read all pairs
  - every value matches; outputs hold across phases 0, 2, 3 and 5–7

Source files
------------

// File: rtl/proc_pkg.sv
// Shared processor constants: datapath widths and phase encoding.
package proc_pkg;

  localparam int unsigned DATA_W   = 16;
  localparam int unsigned ADDR_W   = 3;
  localparam int unsigned NUM_REGS = 2 ** ADDR_W;
  localparam int unsigned PHASE_W  = 3;

  localparam logic [PHASE_W-1:0] PH_IF  = 3'd0;
  localparam logic [PHASE_W-1:0] PH_ID  = 3'd1;
  localparam logic [PHASE_W-1:0] PH_EX  = 3'd2;
  localparam logic [PHASE_W-1:0] PH_MEM = 3'd3;
  localparam logic [PHASE_W-1:0] PH_WB  = 3'd4;

endpackage

// File: rtl/register_file_wb_latch.sv
// Pending write-back latch: captures the decoded write during MEM and
// holds it until the WB phase commits it.
//   clk, reset     : clock, synchronous active-high reset
//   capture        : load a new pending write (MEM phase)
//   commit         : WB phase; clears the pending flag once consumed
//   write_add/data : write-back index and result
//   write_en       : decode's write-back enable
//   p_add, p_data  : held write-back index and data
//   wb_pending     : a captured write awaits commit
module wb_latch
  import proc_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              capture,
  input  logic              commit,
  input  logic [ADDR_W-1:0] write_add,
  input  logic [DATA_W-1:0] write_data,
  input  logic              write_en,
  output logic [ADDR_W-1:0] p_add,
  output logic [DATA_W-1:0] p_data,
  output logic              wb_pending
);

  logic p_valid;

  // Last capture wins; a capture without enable cancels any pending write.
  always_ff @(posedge clk) begin
    if (reset) begin
      p_add   <= '0;
      p_data  <= '0;
      p_valid <= 1'b0;
    end else if (capture) begin
      p_add   <= write_add;
      p_data  <= write_data;
      p_valid <= write_en;
    end else if (commit) begin
      p_valid <= 1'b0;
    end
  end

  assign wb_pending = p_valid;

endmodule

// File: rtl/register_file.sv
// Eight-entry general-purpose register file with registered read ports,
// a pending write-back latch and read bypass from the committing write.
//   clk, reset               : clock, synchronous active-high reset
//   phase                    : processor phase (IF/ID/EX/MEM/WB, 5-7 idle)
//   read_add_a, read_add_b   : operand indices, sampled in ID
//   write_add, writeOrder,
//   write_data               : write-back request, captured in MEM
//   read_data_a, read_data_b : registered operands
//   wb_pending               : a captured write awaits commit
module register_file
  import proc_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic [PHASE_W-1:0] phase,
  input  logic [ADDR_W-1:0]  read_add_a,
  input  logic [ADDR_W-1:0]  read_add_b,
  input  logic [ADDR_W-1:0]  write_add,
  input  logic               writeOrder,
  input  logic [DATA_W-1:0]  write_data,
  output logic [DATA_W-1:0]  read_data_a,
  output logic [DATA_W-1:0]  read_data_b,
  output logic               wb_pending
);

  logic [DATA_W-1:0] regs [NUM_REGS];
  logic [ADDR_W-1:0] p_add;
  logic [DATA_W-1:0] p_data;
  logic              rd_en;
  logic              wr_en;
  logic [DATA_W-1:0] byp_a;
  logic [DATA_W-1:0] byp_b;

  wb_latch u_wb_latch (
    .clk        (clk),
    .reset      (reset),
    .capture    (phase == PH_MEM),
    .commit     (phase == PH_WB),
    .write_add  (write_add),
    .write_data (write_data),
    .write_en   (writeOrder),
    .p_add      (p_add),
    .p_data     (p_data),
    .wb_pending (wb_pending)
  );

  // Kept as discrete nets so a read can be injected alongside a commit.
  assign rd_en = (phase == PH_ID);
  assign wr_en = (phase == PH_WB) && wb_pending;

  // A read colliding with the committing write returns the new value.
  always_comb begin
    byp_a = regs[read_add_a];
    byp_b = regs[read_add_b];
    if (wr_en && (p_add == read_add_a)) byp_a = p_data;
    if (wr_en && (p_add == read_add_b)) byp_b = p_data;
  end

  // Array and read ports.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(NUM_REGS); i++) regs[i] <= '0;
      read_data_a <= '0;
      read_data_b <= '0;
    end else begin
      if (wr_en) regs[p_add] <= p_data;
      if (rd_en) begin
        read_data_a <= byp_a;
        read_data_b <= byp_b;
      end
    end
  end

endmodule

// File: tb/tb_register_file.sv
// Directed bench for register_file with a behavioural reference model.
module tb_register_file;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  phase;
  logic [2:0]  read_add_a, read_add_b, write_add;
  logic        writeOrder;
  logic [15:0] write_data;
  logic [15:0] read_data_a, read_data_b;
  logic        wb_pending;

  int checks = 0;
  int failures = 0;

  // Reference model state
  logic [15:0] m_regs [8];
  logic [2:0]  m_pa;
  logic [15:0] m_pd;
  logic        m_pv;
  logic [15:0] m_a, m_b;
  bit          model_ok = 1'b0;

  register_file dut (
    .clk         (clk),
    .reset       (reset),
    .phase       (phase),
    .read_add_a  (read_add_a),
    .read_add_b  (read_add_b),
    .write_add   (write_add),
    .writeOrder  (writeOrder),
    .write_data  (write_data),
    .read_data_a (read_data_a),
    .read_data_b (read_data_b),
    .wb_pending  (wb_pending)
  );

  always #5 clk = ~clk;

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (model_ok) begin
      checks++;
      if (read_data_a !== m_a) begin
        failures++;
        $display("FAIL model_a t=%0t got=%h exp=%h", $time, read_data_a, m_a);
      end
      checks++;
      if (read_data_b !== m_b) begin
        failures++;
        $display("FAIL model_b t=%0t got=%h exp=%h", $time, read_data_b, m_b);
      end
      checks++;
      if (wb_pending !== m_pv) begin
        failures++;
        $display("FAIL model_pending t=%0t got=%b exp=%b", $time, wb_pending, m_pv);
      end
    end
  end

  task automatic lit(input string name, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  // One clock cycle: drive inputs, take the edge, advance the model.
  task automatic step(input logic rst, input logic [2:0] ph,
                      input logic [2:0] ra, input logic [2:0] rb,
                      input logic [2:0] wa, input logic wo,
                      input logic [15:0] wd, input bit inj);
    reset = rst; phase = ph; read_add_a = ra; read_add_b = rb;
    write_add = wa; writeOrder = wo; write_data = wd;
    if (inj) force dut.rd_en = 1'b1;
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 8; i++) m_regs[i] = 16'h0;
      m_a = 16'h0; m_b = 16'h0; m_pa = 3'd0; m_pd = 16'h0; m_pv = 1'b0;
    end else begin
      if (ph == 3'd4 && m_pv) begin
        m_regs[m_pa] = m_pd;
        m_pv = 1'b0;
      end
      // A read sees the array as it stands after this cycle's commit.
      if (ph == 3'd1 || inj) begin
        m_a = m_regs[ra];
        m_b = m_regs[rb];
      end
      if (ph == 3'd3) begin
        m_pa = wa; m_pd = wd; m_pv = wo;
      end
    end
    model_ok = 1'b1;
    #1;
    if (inj) release dut.rd_en;
  endtask

  initial begin
    reset = 1'b1; phase = 3'd0; read_add_a = 3'd0; read_add_b = 3'd0;
    write_add = 3'd0; writeOrder = 1'b0; write_data = 16'h0;
    #2;

    // Reset then read
    step(1, 0, 0, 0, 0, 0, 16'h0, 0);
    step(0, 1, 3, 7, 0, 0, 16'h0, 0);
    lit("reset_read_a", read_data_a, 16'h0000);
    lit("reset_read_b", read_data_b, 16'h0000);
    lit("reset_pending", 16'(wb_pending), 16'h0);

    // Write then read
    step(0, 3, 0, 0, 5, 1, 16'hBEEF, 0);
    lit("capture_pending", 16'(wb_pending), 16'h1);
    step(0, 4, 0, 0, 0, 0, 16'h0, 0);
    lit("commit_clears", 16'(wb_pending), 16'h0);
    step(0, 1, 5, 0, 0, 0, 16'h0, 0);
    lit("write_read_r5", read_data_a, 16'hBEEF);

    // Suppressed write
    step(0, 3, 0, 0, 2, 0, 16'h1234, 0);
    lit("suppr_pending", 16'(wb_pending), 16'h0);
    step(0, 4, 0, 0, 0, 0, 16'h0, 0);
    step(0, 1, 2, 5, 0, 0, 16'h0, 0);
    lit("suppr_r2", read_data_a, 16'h0000);
    lit("suppr_r5", read_data_b, 16'hBEEF);

    // Reset mid-operation
    step(0, 3, 0, 0, 1, 1, 16'h00FF, 0);
    step(1, 4, 0, 0, 0, 0, 16'h0, 0);
    lit("midrst_pending", 16'(wb_pending), 16'h0);
    step(0, 1, 1, 1, 0, 0, 16'h0, 0);
    lit("midrst_r1", read_data_a, 16'h0000);

    // Last capture wins, then bypass with an injected read
    step(0, 3, 0, 0, 4, 1, 16'h1111, 0);
    step(0, 2, 0, 0, 0, 0, 16'h0, 0);
    step(0, 3, 0, 0, 6, 1, 16'h2222, 0);
    step(0, 4, 0, 0, 0, 0, 16'h0, 0);
    step(0, 1, 6, 4, 0, 0, 16'h0, 0);
    lit("last_wins_r6", read_data_a, 16'h2222);
    lit("last_wins_r4", read_data_b, 16'h0000);
    step(0, 3, 0, 0, 6, 1, 16'h3333, 0);
    step(0, 4, 4, 6, 0, 0, 16'h0, 1);
    lit("bypass_b", read_data_b, 16'h3333);
    lit("bypass_a_r4", read_data_a, 16'h0000);
    step(0, 4, 0, 0, 0, 0, 16'h0, 0);
    step(0, 1, 6, 6, 0, 0, 16'h0, 0);
    lit("double_wb_r6", read_data_a, 16'h3333);

    // Sweep all registers
    for (int i = 0; i < 8; i++) begin
      step(0, 3, 0, 0, 3'(i), 1, 16'(i * 16'h1001), 0);
      step(0, 4, 0, 0, 0, 0, 16'h0, 0);
    end
    for (int i = 0; i < 8; i++) begin
      step(0, 1, 3'(i), 3'(7 - i), 0, 0, 16'h0, 0);
      lit("sweep_a", read_data_a, 16'(i * 16'h1001));
      lit("sweep_b", read_data_b, 16'((7 - i) * 16'h1001));
    end

    // Outputs hold outside ID (last read: a=r7, b=r0)
    step(0, 0, 1, 2, 0, 0, 16'h0, 0);
    step(0, 2, 3, 4, 0, 0, 16'h0, 0);
    step(0, 3, 5, 6, 3, 0, 16'hAAAA, 0);
    step(0, 5, 1, 1, 0, 0, 16'h0, 0);
    step(0, 6, 2, 2, 0, 0, 16'h0, 0);
    step(0, 7, 3, 3, 0, 0, 16'h0, 0);
    lit("hold_a", read_data_a, 16'h7007);
    lit("hold_b", read_data_b, 16'h0000);
    step(0, 4, 0, 0, 0, 0, 16'h0, 0);
    step(0, 1, 3, 3, 0, 0, 16'h0, 0);
    lit("hold_r3", read_data_a, 16'h3003);

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
